// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter.
// Holds the shift-op encoding and a helper that counts pipeline registers
// selected by a placement mask.
package shifter_pkg;

    localparam logic [1:0] SHOP_SLL = 2'b00;
    localparam logic [1:0] SHOP_SRL = 2'b01;
    localparam logic [1:0] SHOP_SRA = 2'b10;
    localparam logic [1:0] SHOP_ROR = 2'b11;

    // Number of register slots enabled by mask bits below 'stages'.
    function automatic int unsigned pipe_regs(input logic [31:0] mask,
                                              input int unsigned stages);
        int unsigned n;
        n = 0;
        for (int unsigned j = 0; j < 32; j++) begin
            if (j < stages && mask[j]) begin
                n = n + 1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/shifter_pipelined_if.sv
// Handshake bus of the pipelined shifter.
// Request side : in_valid/in_ready, data_operandA, ctrl_shiftamt,
//                ctrl_shiftop, in_tag
// Response side: out_valid/out_ready, data_result, out_tag
// master = the issuing/consuming agent, slave = the shifter.
interface shifter_pipelined_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4
);
    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   data_operandA;
    logic [SHAMT_W-1:0] ctrl_shiftamt;
    logic [1:0]         ctrl_shiftop;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   data_result;
    logic [TAG_W-1:0]   out_tag;

    modport master (
        output in_valid, data_operandA, ctrl_shiftamt, ctrl_shiftop, in_tag,
        output out_ready,
        input  in_ready, out_valid, data_result, out_tag
    );

    modport slave (
        input  in_valid, data_operandA, ctrl_shiftamt, ctrl_shiftop, in_tag,
        input  out_ready,
        output in_ready, out_valid, data_result, out_tag
    );

endinterface

// File: rtl/shift_stage.sv
// One combinational log stage of the barrel shifter: shifts by the fixed
// amount SHIFT when en_i is set, otherwise passes data through.
// Ports: data_i (operand), op_i (SLL/SRL/SRA/ROR), en_i (apply shift),
//        data_o (result).
module shift_stage
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHIFT = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [1:0]       op_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] data_o
);

    // SRA keeps the operand sign in the MSB at every stage, so the local
    // MSB is a valid fill source.
    always_comb begin
        data_o = data_i;
        if (en_i) begin
            case (op_i)
                SHOP_SLL: data_o = {data_i[WIDTH-1-SHIFT:0], {SHIFT{1'b0}}};
                SHOP_SRL: data_o = {{SHIFT{1'b0}}, data_i[WIDTH-1:SHIFT]};
                SHOP_SRA: data_o = {{SHIFT{data_i[WIDTH-1]}}, data_i[WIDTH-1:SHIFT]};
                SHOP_ROR: data_o = {data_i[SHIFT-1:0], data_i[WIDTH-1:SHIFT]};
                default:  data_o = data_i;
            endcase
        end
    end

endmodule

// File: rtl/shifter_pipelined.sv
// Parametrised logarithmic barrel shifter with optional register slots
// between log stages, chained by valid/ready handshakes.
// Ports: clock, reset (sync, active-high), bus (slave side of
//        shifter_pipelined_if: request in, result + tag out).
// PIPE_MASK bit j places a slot after stage j (stage 0 shifts by WIDTH/2).
module shifter_pipelined
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned TAG_W     = 4,
    parameter logic [31:0] PIPE_MASK = 32'h5
) (
    input  logic               clock,
    input  logic               reset,
    shifter_pipelined_if.slave bus
);

    localparam int unsigned SHAMT_W = $clog2(WIDTH);
    localparam int unsigned LATENCY = pipe_regs(PIPE_MASK, SHAMT_W);

    logic [SHAMT_W-1:0] slot_v;
    logic [SHAMT_W-1:0] rdy;

    // Ready seen at the input of each stage: a slot frees up when empty or
    // when its own downstream is ready, so empty slots absorb bubbles.
    always_comb begin : p_ready
        logic r;
        r   = bus.out_ready;
        rdy = '0;
        for (int k = SHAMT_W - 1; k >= 0; k--) begin
            if (PIPE_MASK[k]) begin
                r = !slot_v[k] || r;
            end
            rdy[k] = r;
        end
    end

    for (genvar j = 0; j < SHAMT_W; j++) begin : g_stage
        logic [WIDTH-1:0]   s_data;
        logic [1:0]         s_op;
        logic [SHAMT_W-1:0] s_shamt;
        logic [TAG_W-1:0]   s_tag;
        logic               s_valid;
        logic [WIDTH-1:0]   x_data;
        logic [WIDTH-1:0]   o_data;
        logic [1:0]         o_op;
        logic [SHAMT_W-1:0] o_shamt;
        logic [TAG_W-1:0]   o_tag;
        logic               o_valid;

        if (j == 0) begin : g_head
            assign s_data  = bus.data_operandA;
            assign s_op    = bus.ctrl_shiftop;
            assign s_shamt = bus.ctrl_shiftamt;
            assign s_tag   = bus.in_tag;
            assign s_valid = bus.in_valid;
        end else begin : g_link
            assign s_data  = g_stage[j-1].o_data;
            assign s_op    = g_stage[j-1].o_op;
            assign s_shamt = g_stage[j-1].o_shamt;
            assign s_tag   = g_stage[j-1].o_tag;
            assign s_valid = g_stage[j-1].o_valid;
        end

        shift_stage #(
            .WIDTH (WIDTH),
            .SHIFT (1 << (SHAMT_W - 1 - j))
        ) u_stage (
            .data_i (s_data),
            .op_i   (s_op),
            .en_i   (s_shamt[SHAMT_W-1-j]),
            .data_o (x_data)
        );

        if (PIPE_MASK[j]) begin : g_slot
            logic               v_q;
            logic               v_d;
            logic [WIDTH-1:0]   data_q;
            logic [1:0]         op_q;
            logic [SHAMT_W-1:0] shamt_q;
            logic [TAG_W-1:0]   tag_q;

            assign v_d = rdy[j] ? s_valid : v_q;

            // Payload only moves with a valid op, so a stalled result stays put.
            always_ff @(posedge clock) begin
                if (reset) begin
                    v_q     <= 1'b0;
                    data_q  <= '0;
                    op_q    <= '0;
                    shamt_q <= '0;
                    tag_q   <= '0;
                end else begin
                    v_q <= v_d;
                    if (rdy[j] && s_valid) begin
                        data_q  <= x_data;
                        op_q    <= s_op;
                        shamt_q <= s_shamt;
                        tag_q   <= s_tag;
                    end
                end
            end

            assign o_valid   = v_q;
            assign o_data    = data_q;
            assign o_op      = op_q;
            assign o_shamt   = shamt_q;
            assign o_tag     = tag_q;
            assign slot_v[j] = v_q;
        end else begin : g_wire
            assign o_valid   = s_valid;
            assign o_data    = x_data;
            assign o_op      = s_op;
            assign o_shamt   = s_shamt;
            assign o_tag     = s_tag;
            assign slot_v[j] = 1'b0;
        end
    end

    // With no slots the shifter is transparent to backpressure.
    assign bus.in_ready    = (LATENCY == 0) ? bus.out_ready : rdy[0];
    assign bus.out_valid   = g_stage[SHAMT_W-1].o_valid;
    assign bus.data_result = g_stage[SHAMT_W-1].o_data;
    assign bus.out_tag     = g_stage[SHAMT_W-1].o_tag;

    // Op and shift amount are spent once the last stage has used them.
    logic unused_tail;
    assign unused_tail = ^{g_stage[SHAMT_W-1].o_op, g_stage[SHAMT_W-1].o_shamt};

endmodule

// File: tb/tb_shifter_pipelined.sv
// Directed bench for shifter_pipelined: L=2 (mask 'h5), L=0 and L=5 builds.
module tb_shifter_pipelined
    import shifter_pkg::*;
;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    shifter_pipelined_if #(.WIDTH(32), .TAG_W(4)) if_a ();
    shifter_pipelined_if #(.WIDTH(32), .TAG_W(4)) if_z ();
    shifter_pipelined_if #(.WIDTH(32), .TAG_W(4)) if_f ();

    shifter_pipelined #(.WIDTH(32), .TAG_W(4), .PIPE_MASK(32'h5)) dut_a (
        .clock (clk), .reset (rst), .bus (if_a)
    );
    shifter_pipelined #(.WIDTH(32), .TAG_W(4), .PIPE_MASK(32'h0)) dut_z (
        .clock (clk), .reset (rst), .bus (if_z)
    );
    shifter_pipelined #(.WIDTH(32), .TAG_W(4), .PIPE_MASK(32'h1F)) dut_f (
        .clock (clk), .reset (rst), .bus (if_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (if_a.out_valid !== 1'b0 || if_a.data_result !== 32'h0 ||
            if_a.out_tag !== 4'h0 || if_a.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state got v=%b d=%h t=%h r=%b exp v=0 d=0 t=0 r=1",
                     if_a.out_valid, if_a.data_result, if_a.out_tag, if_a.in_ready);
        end
        checks++;
        if (if_f.out_valid !== 1'b0 || if_f.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_deep got v=%b r=%b exp v=0 r=1", if_f.out_valid, if_f.in_ready);
        end
    endtask

    task automatic test_latency();
        logic [1:0]  ops [2];
        logic [31:0] exp [2];
        ops = '{SHOP_SRA, SHOP_SRL};
        exp = '{32'hFFFF_FFFF, 32'h0000_0001};
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            if_a.in_valid = 1'b1; if_a.out_ready = 1'b1;
            if_a.data_operandA = 32'h8000_0000; if_a.ctrl_shiftamt = 5'd31;
            if_a.ctrl_shiftop = ops[i]; if_a.in_tag = 4'(i + 5);
            #1;
            checks++;
            if (if_a.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL lat_in_ready[%0d] got %b exp 1", i, if_a.in_ready);
            end
            @(posedge clk); #1;
            if_a.in_valid = 1'b0;
            #1;
            checks++;
            if (if_a.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL lat_early[%0d] got out_valid %b exp 0", i, if_a.out_valid);
            end
            @(posedge clk); #2;
            checks++;
            if (if_a.out_valid !== 1'b1 || if_a.data_result !== exp[i] ||
                if_a.out_tag !== 4'(i + 5)) begin
                errors++;
                $display("FAIL lat_result[%0d] got v=%b d=%h t=%h exp v=1 d=%h t=%h",
                         i, if_a.out_valid, if_a.data_result, if_a.out_tag, exp[i], 4'(i + 5));
            end
        end
    endtask

    task automatic test_shift_modes();
        logic [1:0]  ops  [3];
        logic [4:0]  amt  [3];
        logic [31:0] opnd [3];
        logic [31:0] exp  [3];
        ops  = '{SHOP_SLL, SHOP_ROR, SHOP_ROR};
        amt  = '{5'd31, 5'd1, 5'd16};
        opnd = '{32'h0000_0001, 32'h0000_0001, 32'h1234_5678};
        exp  = '{32'h8000_0000, 32'h8000_0000, 32'h5678_1234};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if_a.in_valid = 1'b1; if_a.out_ready = 1'b1;
            if_a.data_operandA = opnd[i]; if_a.ctrl_shiftamt = amt[i];
            if_a.ctrl_shiftop = ops[i]; if_a.in_tag = 4'(i + 1);
            @(posedge clk); #1;
            if_a.in_valid = 1'b0;
            @(posedge clk); #2;
            checks++;
            if (if_a.out_valid !== 1'b1 || if_a.data_result !== exp[i] ||
                if_a.out_tag !== 4'(i + 1)) begin
                errors++;
                $display("FAIL mode[%0d] got v=%b d=%h t=%h exp v=1 d=%h t=%h",
                         i, if_a.out_valid, if_a.data_result, if_a.out_tag, exp[i], 4'(i + 1));
            end
        end
    endtask

    task automatic test_shamt_zero();
        logic [1:0] ops [4];
        int tx = 0;
        int rx = 0;
        ops = '{SHOP_SLL, SHOP_SRL, SHOP_SRA, SHOP_ROR};
        for (int cyc = 0; cyc < 12 && rx < 4; cyc++) begin
            @(posedge clk); #1;
            if_a.out_ready = 1'b1;
            if_a.in_valid = (tx < 4);
            if_a.data_operandA = 32'hDEAD_BEEF; if_a.ctrl_shiftamt = 5'd0;
            if_a.ctrl_shiftop = ops[tx % 4]; if_a.in_tag = 4'(tx + 1);
            #1;
            if (if_a.out_valid === 1'b1) begin
                checks++;
                if (if_a.data_result !== 32'hDEAD_BEEF || if_a.out_tag !== 4'(rx + 1)) begin
                    errors++;
                    $display("FAIL zero_shift[%0d] got d=%h t=%h exp d=deadbeef t=%h",
                             rx, if_a.data_result, if_a.out_tag, 4'(rx + 1));
                end
                rx++;
            end
            if (if_a.in_valid && if_a.in_ready) tx++;
        end
        if_a.in_valid = 1'b0;
        checks++;
        if (rx != 4) begin
            errors++;
            $display("FAIL zero_count got %0d exp 4", rx);
        end
    endtask

    task automatic test_back_to_back();
        int tx = 0;
        int rx = 0;
        for (int cyc = 0; cyc < 20 && rx < 4; cyc++) begin
            @(posedge clk); #1;
            if_a.out_ready = (cyc >= 5);
            if_a.in_valid = (tx < 4);
            if_a.data_operandA = 32'(tx + 1); if_a.ctrl_shiftamt = 5'd4;
            if_a.ctrl_shiftop = SHOP_SLL; if_a.in_tag = 4'(tx);
            #1;
            if (cyc >= 2 && cyc <= 4) begin
                checks++;
                if (if_a.in_ready !== 1'b0 || if_a.out_valid !== 1'b1 || tx != 2 ||
                    if_a.data_result !== 32'h10 || if_a.out_tag !== 4'h0) begin
                    errors++;
                    $display("FAIL stall_hold[%0d] got r=%b v=%b acc=%0d d=%h t=%h exp r=0 v=1 acc=2 d=10 t=0",
                             cyc, if_a.in_ready, if_a.out_valid, tx, if_a.data_result, if_a.out_tag);
                end
            end
            if (cyc >= 5 && cyc <= 8) begin
                checks++;
                if (if_a.out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL drain_rate[%0d] got out_valid %b exp 1", cyc, if_a.out_valid);
                end
            end
            if (if_a.out_valid === 1'b1 && if_a.out_ready === 1'b1) begin
                checks++;
                if (if_a.data_result !== 32'((rx + 1) << 4) || if_a.out_tag !== 4'(rx)) begin
                    errors++;
                    $display("FAIL drain_order[%0d] got d=%h t=%h exp d=%h t=%h",
                             rx, if_a.data_result, if_a.out_tag, 32'((rx + 1) << 4), 4'(rx));
                end
                rx++;
            end
            if (if_a.in_valid && if_a.in_ready) tx++;
        end
        if_a.in_valid = 1'b0;
        checks++;
        if (tx != 4 || rx != 4) begin
            errors++;
            $display("FAIL stream_count got acc=%0d done=%0d exp 4 4", tx, rx);
        end
    endtask

    task automatic test_reset_midflight();
        bit leaked = 1'b0;
        @(posedge clk); #1;
        if_a.out_ready = 1'b0; if_a.in_valid = 1'b1;
        if_a.data_operandA = 32'h0000_00FF; if_a.ctrl_shiftamt = 5'd8;
        if_a.ctrl_shiftop = SHOP_SLL; if_a.in_tag = 4'hA;
        @(posedge clk); #1;
        if_a.data_operandA = 32'h0000_0F0F; if_a.ctrl_shiftamt = 5'd4; if_a.in_tag = 4'hB;
        @(posedge clk); #1;
        if_a.in_valid = 1'b0;
        #1;
        checks++;
        if (if_a.out_valid !== 1'b1 || if_a.data_result !== 32'h0000_FF00) begin
            errors++;
            $display("FAIL pre_reset got v=%b d=%h exp v=1 d=0000ff00", if_a.out_valid, if_a.data_result);
        end
        rst = 1'b1;
        if_a.in_valid = 1'b1; if_a.data_operandA = 32'h0000_0003; if_a.in_tag = 4'hC;
        @(posedge clk); #1;
        rst = 1'b0; if_a.in_valid = 1'b0; if_a.out_ready = 1'b1;
        #1;
        checks++;
        if (if_a.out_valid !== 1'b0 || if_a.data_result !== 32'h0 ||
            if_a.out_tag !== 4'h0 || if_a.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset got v=%b d=%h t=%h r=%b exp v=0 d=0 t=0 r=1",
                     if_a.out_valid, if_a.data_result, if_a.out_tag, if_a.in_ready);
        end
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(posedge clk); #2;
            if (if_a.out_valid !== 1'b0) leaked = 1'b1;
        end
        checks++;
        if (leaked) begin
            errors++;
            $display("FAIL reset_discard got leaked=1 exp leaked=0");
        end
    endtask

    task automatic test_comb_build();
        #1;
        if_z.in_valid = 1'b1; if_z.out_ready = 1'b1;
        if_z.data_operandA = 32'hF000_0000; if_z.ctrl_shiftamt = 5'd4;
        if_z.ctrl_shiftop = SHOP_SRA; if_z.in_tag = 4'h6;
        #1;
        checks++;
        if (if_z.out_valid !== 1'b1 || if_z.data_result !== 32'hFF00_0000 ||
            if_z.out_tag !== 4'h6 || if_z.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL comb_result got v=%b d=%h t=%h r=%b exp v=1 d=ff000000 t=6 r=1",
                     if_z.out_valid, if_z.data_result, if_z.out_tag, if_z.in_ready);
        end
        if_z.out_ready = 1'b0; if_z.in_valid = 1'b0;
        #1;
        checks++;
        if (if_z.in_ready !== 1'b0 || if_z.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL comb_handshake got r=%b v=%b exp r=0 v=0", if_z.in_ready, if_z.out_valid);
        end
        if_z.out_ready = 1'b1;
    endtask

    task automatic test_deep_build();
        logic [1:0]  ops  [3];
        logic [31:0] opnd [3];
        logic [31:0] exp  [3];
        ops  = '{SHOP_SRA, SHOP_SRL, SHOP_ROR};
        opnd = '{32'hF000_0000, 32'hF000_0000, 32'h0000_000F};
        exp  = '{32'hFF00_0000, 32'h0F00_0000, 32'hF000_0000};
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(posedge clk); #1;
            if_f.out_ready = 1'b1;
            if_f.in_valid = (cyc < 3);
            if_f.data_operandA = opnd[cyc % 3]; if_f.ctrl_shiftamt = 5'd4;
            if_f.ctrl_shiftop = ops[cyc % 3]; if_f.in_tag = 4'(cyc + 7);
            #1;
            if (cyc < 3) begin
                checks++;
                if (if_f.in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL deep_in_ready[%0d] got %b exp 1", cyc, if_f.in_ready);
                end
            end
            checks++;
            if (cyc >= 5 && cyc <= 7) begin
                if (if_f.out_valid !== 1'b1 || if_f.data_result !== exp[cyc-5] ||
                    if_f.out_tag !== 4'(cyc + 2)) begin
                    errors++;
                    $display("FAIL deep_out[%0d] got v=%b d=%h t=%h exp v=1 d=%h t=%h",
                             cyc, if_f.out_valid, if_f.data_result, if_f.out_tag,
                             exp[cyc-5], 4'(cyc + 2));
                end
            end else if (if_f.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL deep_idle[%0d] got out_valid %b exp 0", cyc, if_f.out_valid);
            end
        end
        if_f.in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        if_a.in_valid = 1'b0; if_a.out_ready = 1'b1; if_a.data_operandA = '0;
        if_a.ctrl_shiftamt = '0; if_a.ctrl_shiftop = '0; if_a.in_tag = '0;
        if_z.in_valid = 1'b0; if_z.out_ready = 1'b1; if_z.data_operandA = '0;
        if_z.ctrl_shiftamt = '0; if_z.ctrl_shiftop = '0; if_z.in_tag = '0;
        if_f.in_valid = 1'b0; if_f.out_ready = 1'b1; if_f.data_operandA = '0;
        if_f.ctrl_shiftamt = '0; if_f.ctrl_shiftop = '0; if_f.in_tag = '0;

        test_reset();
        test_latency();
        test_shift_modes();
        test_shamt_zero();
        test_back_to_back();
        test_reset_midflight();
        test_comb_build();
        test_deep_build();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shifter_pipelined.md
Name: shifter_pipelined

Overview:
Parametrised, pipelined logarithmic barrel shifter for the CPU execute path. It is the successor to the fixed 32-bit, SRA-only combinational shifter. It generalises data width, adds four shift modes (SLL, SRL, SRA, ROR) and lets the build choose where pipeline registers sit between log stages. Stages connect through valid/ready handshakes and carry a tag for out-of-order bookkeeping in the issue logic.

Parameters:
WIDTH, 32, data width; must be a power of two, >= 2
SHAMT_W, $clog2(WIDTH), shift-amount width; derived, do not override
TAG_W, 4, width of the sideband tag carried alongside each operation
PIPE_MASK, 32'h5, bit j = 1 places a register after log stage j; stage 0 shifts by WIDTH/2, stage SHAMT_W-1 shifts by 1; bits >= SHAMT_W ignored

Ports:
clock  input  1  single clock, rising edge
reset  input  1  synchronous, active-high
in_valid  input  1  operation offered
in_ready  output  1  shifter can accept this cycle
data_operandA  input  WIDTH  operand
ctrl_shiftamt  input  SHAMT_W  shift amount, unsigned
ctrl_shiftop  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR
in_tag  input  TAG_W  sideband tag, returned unchanged
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
data_result  output  WIDTH  shifted result
out_tag  output  TAG_W  tag of the result

Behaviour:
- Latency L = popcount(PIPE_MASK[SHAMT_W-1:0]) cycles from an accepted input to out_valid. Capacity is L operations.
- L = 0: purely combinational. out_valid = in_valid, in_ready = out_ready, no state.
- Stage j applies a fixed shift of S = 2^(SHAMT_W-1-j) when shamt bit (SHAMT_W-1-j) is 1; otherwise it passes data through.
- Per-stage mode rules:
  - SLL fills zeros at the LSBs.
  - SRL fills zeros at the MSBs.
  - SRA fills copies of the operand sign bit. The intermediate MSB equals the original sign, so each stage may use its own input MSB.
  - ROR wraps the low S bits to the top.
- Op, the remaining shamt bits and the tag are registered alongside data at every pipeline slot.
- Each slot k holds a valid bit v_k.
  - Slot k loads when ready_k = !v_k || ready_{k+1}. The last slot's downstream ready is out_ready.
  - in_ready = ready_0.
  - This gives full throughput (one op per cycle) with bubble collapse: an empty slot accepts even when the output is stalled.
- Accept: in_valid && in_ready. Complete: out_valid && out_ready.
- Stall: while out_valid && !out_ready, data_result and out_tag are held bit-stable.
- Simultaneous accept and complete on a full pipeline is legal and loses nothing. Ordering is strict FIFO.
- shamt = 0 returns the operand unchanged in every mode. shamt = WIDTH-1 is the maximal case. There is no out-of-range shamt, since its width is exact.
- Reset, at any time including mid-flight:
  - Next cycle: all v_k = 0, out_valid = 0, data_result = 0, out_tag = 0, in_ready = 1 (L > 0).
  - In-flight operations are discarded and never emerge.
  - Inputs presented in the reset cycle are not accepted.
- Data and tag registers reset to 0.
- No X may propagate to out_valid from an uninitialised slot.

Decomposition:
- Package shifter_pkg holds:
  - The op encoding constants SHOP_SLL = 2'b00, SHOP_SRL = 2'b01, SHOP_SRA = 2'b10, SHOP_ROR = 2'b11.
  - A function returning the register count for a given mask.
- Sub-module shift_stage is combinational: WIDTH and SHIFT parameters; inputs data, op and enable; output data. It is instantiated SHAMT_W times in a generate loop.
- Optional pipeline slots are generated per PIPE_MASK bit in the top level.

Test Plan:
1. WIDTH=32, PIPE_MASK='h5 (L=2): SRA 0x8000_0000 by 31 -> 0xFFFF_FFFF exactly 2 cycles after accept. SRL same operand -> 0x0000_0001.
2. SLL 0x0000_0001 by 31 -> 0x8000_0000. ROR 0x0000_0001 by 1 -> 0x8000_0000. ROR 0x1234_5678 by 16 -> 0x5678_1234.
3. shamt=0, operand 0xDEAD_BEEF, all four ops -> 0xDEAD_BEEF each, tags 1..4 returned in order.
4. Stream 4 ops (tags 0..3) with out_ready=0 for 3 cycles:
   - in_ready falls after 2 accepts.
   - data_result is stable during the stall.
   - After release, results drain in tag order, one per cycle, with no loss.
5. Reset while 2 ops are in flight -> next cycle out_valid=0, data_result=0, in_ready=1. Neither op ever appears at the output.
6. PIPE_MASK=0 build: SRA 0xF000_0000 by 4 -> 0xFF00_0000 in the same cycle, out_valid=in_valid. PIPE_MASK='h1F (L=5): the same op yields its result 5 cycles after accept at full throughput.
